// File: rtl/mult_accum16_if.sv
// Handshake and data bundle between the multiplier and the product accumulator.
// Clock and reset stay plain module ports.
interface mult_accum16_if;
    logic        load;
    logic [15:0] prod;
    logic        clr;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sat;
    logic        busy;
    logic        overrun;

    modport master (
        output load, prod, clr, out_ready,
        input  out_valid, out_data, out_sat, busy, overrun
    );

    modport slave (
        input  load, prod, clr, out_ready,
        output out_valid, out_data, out_sat, busy, overrun
    );
endinterface

// File: rtl/mult_accum16.sv
// Tracks the serial multiplier's 16-clock product phase, accumulates TAPS products
// into a 20-bit sum and delivers the saturated 16-bit result over valid/ready.
module mult_accum16 #(
    parameter int unsigned TAPS = 4
) (
    input logic           clk,
    input logic           rst,
    mult_accum16_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StCount} state_e;

    localparam logic [3:0] LastTerm = 4'(TAPS - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  term_q, term_d;
    logic [19:0] acc_q, acc_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_sat_q, out_sat_d;
    logic        overrun_q, overrun_d;

    logic [19:0] sum;
    logic        sum_sat;

    assign sum     = acc_q + {4'b0000, bus.prod};
    assign sum_sat = |sum[19:16];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        term_d      = term_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        overrun_d   = overrun_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (bus.clr) begin
            // Clear wins over any sample; a simultaneous load still starts a fresh phase.
            acc_d     = '0;
            term_d    = '0;
            overrun_d = 1'b0;
            state_d   = bus.load ? StCount : StIdle;
            cnt_d     = bus.load ? 4'd15 : 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.load) begin
                        state_d = StCount;
                        cnt_d   = 4'd15;
                    end
                end
                StCount: begin
                    if (cnt_q != 4'd0) begin
                        if (bus.load) begin
                            cnt_d     = 4'd15;
                            overrun_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end else begin
                        if (term_q == LastTerm) begin
                            // A pending result that is not leaving this edge keeps priority.
                            if (!out_valid_q || bus.out_ready) begin
                                out_data_d  = sum_sat ? 16'hFFFF : sum[15:0];
                                out_sat_d   = sum_sat;
                                out_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                            acc_d  = '0;
                            term_d = '0;
                        end else begin
                            acc_d  = sum;
                            term_d = term_q + 4'd1;
                        end
                        state_d = bus.load ? StCount : StIdle;
                        cnt_d   = bus.load ? 4'd15 : 4'd0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            term_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            term_q      <= term_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.busy      = (state_q == StCount);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_mult_accum16.sv
// Directed bench for mult_accum16: three instances (TAPS = 4, 1, 2) driven from one
// linear stimulus sequence with hand-computed expectations.
module tb_mult_accum16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Index 0: TAPS=4, index 1: TAPS=1, index 2: TAPS=2.
    logic        load_v  [3];
    logic [15:0] prod_v  [3];
    logic        clr_v   [3];
    logic        ready_v [3];
    logic        valid_v [3];
    logic [15:0] data_v  [3];
    logic        sat_v   [3];
    logic        busy_v  [3];
    logic        ovr_v   [3];

    mult_accum16_if bus4 ();
    mult_accum16_if bus1 ();
    mult_accum16_if bus2 ();

    assign bus4.load      = load_v[0];
    assign bus4.prod      = prod_v[0];
    assign bus4.clr       = clr_v[0];
    assign bus4.out_ready = ready_v[0];
    assign valid_v[0]     = bus4.out_valid;
    assign data_v[0]      = bus4.out_data;
    assign sat_v[0]       = bus4.out_sat;
    assign busy_v[0]      = bus4.busy;
    assign ovr_v[0]       = bus4.overrun;

    assign bus1.load      = load_v[1];
    assign bus1.prod      = prod_v[1];
    assign bus1.clr       = clr_v[1];
    assign bus1.out_ready = ready_v[1];
    assign valid_v[1]     = bus1.out_valid;
    assign data_v[1]      = bus1.out_data;
    assign sat_v[1]       = bus1.out_sat;
    assign busy_v[1]      = bus1.busy;
    assign ovr_v[1]       = bus1.overrun;

    assign bus2.load      = load_v[2];
    assign bus2.prod      = prod_v[2];
    assign bus2.clr       = clr_v[2];
    assign bus2.out_ready = ready_v[2];
    assign valid_v[2]     = bus2.out_valid;
    assign data_v[2]      = bus2.out_data;
    assign sat_v[2]       = bus2.out_sat;
    assign busy_v[2]      = bus2.busy;
    assign ovr_v[2]       = bus2.overrun;

    mult_accum16 #(.TAPS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    mult_accum16 #(.TAPS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mult_accum16 #(.TAPS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load edge E0.
    task automatic start(input int k);
        load_v[k] = 1'b1;
        tick();
        load_v[k] = 1'b0;
    endtask

    // Run edges E1..E16 with prod presented; chain reloads on E16.
    task automatic finish(input int k, input logic [15:0] p, input logic chain);
        prod_v[k] = p;
        repeat (15) tick();
        load_v[k] = chain;
        tick();
        load_v[k] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_v[i]  = 1'b0;
            prod_v[i]  = '0;
            clr_v[i]   = 1'b0;
            ready_v[i] = 1'b0;
        end
        #1;
        check("rst_valid", 32'(valid_v[0]), 32'd0);
        check("rst_data", 32'(data_v[0]), 32'h0);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_ovr", 32'(ovr_v[0]), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Four terms of 0x1000, back to back, sink always ready.
        ready_v[0] = 1'b1;
        start(0);
        check("t1_busy", 32'(busy_v[0]), 32'd1);
        finish(0, 16'h1000, 1'b1);
        check("t1_no_valid_early", 32'(valid_v[0]), 32'd0);
        check("t1_busy_chain", 32'(busy_v[0]), 32'd1);
        finish(0, 16'h1000, 1'b1);
        finish(0, 16'h1000, 1'b1);
        finish(0, 16'h1000, 1'b0);
        check("t1_valid", 32'(valid_v[0]), 32'd1);
        check("t1_data", 32'(data_v[0]), 32'h4000);
        check("t1_sat", 32'(sat_v[0]), 32'd0);
        check("t1_ovr", 32'(ovr_v[0]), 32'd0);
        check("t1_busy_done", 32'(busy_v[0]), 32'd0);
        tick();
        check("t1_valid_drop", 32'(valid_v[0]), 32'd0);

        // Saturation, then a fresh frame proves the accumulator was cleared.
        start(0);
        finish(0, 16'h8000, 1'b1);
        finish(0, 16'h8000, 1'b1);
        finish(0, 16'h0001, 1'b1);
        finish(0, 16'h0000, 1'b1);
        check("t2_valid", 32'(valid_v[0]), 32'd1);
        check("t2_data", 32'(data_v[0]), 32'hFFFF);
        check("t2_sat", 32'(sat_v[0]), 32'd1);
        finish(0, 16'h0001, 1'b1);
        check("t2_valid_drop", 32'(valid_v[0]), 32'd0);
        finish(0, 16'h0001, 1'b1);
        finish(0, 16'h0001, 1'b1);
        finish(0, 16'h0001, 1'b0);
        check("t2_data2", 32'(data_v[0]), 32'h0004);
        check("t2_sat2", 32'(sat_v[0]), 32'd0);
        tick();

        // TAPS=1, sink stalled: second result dropped and overrun raised.
        start(1);
        finish(1, 16'h0011, 1'b1);
        check("t3_valid1", 32'(valid_v[1]), 32'd1);
        check("t3_data1", 32'(data_v[1]), 32'h0011);
        check("t3_ovr1", 32'(ovr_v[1]), 32'd0);
        finish(1, 16'h0022, 1'b0);
        check("t3_valid2", 32'(valid_v[1]), 32'd1);
        check("t3_data2", 32'(data_v[1]), 32'h0011);
        check("t3_ovr2", 32'(ovr_v[1]), 32'd1);
        ready_v[1] = 1'b1;
        tick();
        ready_v[1] = 1'b0;
        check("t3_valid_drop", 32'(valid_v[1]), 32'd0);
        check("t3_data_hold", 32'(data_v[1]), 32'h0011);

        // Restart at E7 counts as a single term.
        start(0);
        repeat (6) tick();
        load_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        check("t4_ovr", 32'(ovr_v[0]), 32'd1);
        check("t4_busy", 32'(busy_v[0]), 32'd1);
        finish(0, 16'h0005, 1'b1);
        finish(0, 16'h0000, 1'b1);
        finish(0, 16'h0000, 1'b1);
        check("t4_not_yet", 32'(valid_v[0]), 32'd0);
        finish(0, 16'h0000, 1'b0);
        check("t4_valid", 32'(valid_v[0]), 32'd1);
        check("t4_data", 32'(data_v[0]), 32'h0005);
        tick();

        // TAPS=2: restart raises overrun, clr mid-frame clears it and the partial sum.
        ready_v[2] = 1'b1;
        start(2);
        repeat (3) tick();
        start(2);
        check("t5_ovr_set", 32'(ovr_v[2]), 32'd1);
        finish(2, 16'h0100, 1'b1);
        repeat (5) tick();
        clr_v[2] = 1'b1;
        tick();
        clr_v[2] = 1'b0;
        check("t5_clr_busy", 32'(busy_v[2]), 32'd0);
        check("t5_clr_ovr", 32'(ovr_v[2]), 32'd0);
        check("t5_clr_valid", 32'(valid_v[2]), 32'd0);
        start(2);
        finish(2, 16'h0003, 1'b1);
        check("t5_one_term", 32'(valid_v[2]), 32'd0);
        finish(2, 16'h0003, 1'b0);
        check("t5_valid", 32'(valid_v[2]), 32'd1);
        check("t5_data", 32'(data_v[2]), 32'h0006);
        check("t5_ovr", 32'(ovr_v[2]), 32'd0);
        tick();

        // Async reset mid-COUNT while a result is pending.
        clr_v[0] = 1'b1;
        tick();
        clr_v[0] = 1'b0;
        ready_v[0] = 1'b0;
        start(0);
        finish(0, 16'h0001, 1'b1);
        finish(0, 16'h0001, 1'b1);
        finish(0, 16'h0001, 1'b1);
        finish(0, 16'h0001, 1'b1);
        check("t6_valid_pre", 32'(valid_v[0]), 32'd1);
        check("t6_data_pre", 32'(data_v[0]), 32'h0004);
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(valid_v[0]), 32'd0);
        check("t6_data", 32'(data_v[0]), 32'h0);
        check("t6_sat", 32'(sat_v[0]), 32'd0);
        check("t6_busy", 32'(busy_v[0]), 32'd0);
        check("t6_ovr", 32'(ovr_v[0]), 32'd0);
        prod_v[0] = 16'h0007;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t6_no_pulse", 32'(valid_v[0]), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
